// File: rtl/rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ    = 3;
    localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_arbiter_if.sv
// Requester-side bus of the arbiter: request levels in, one-hot grant and status out.
interface rr_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             preempt;

    // master is the arbiter, slave is the requester/datapath side
    modport master (input req, output gnt, gnt_id, busy, preempt);
    modport slave  (output req, input gnt, gnt_id, busy, preempt);
endinterface

// File: rtl/rr_arbiter_pick.sv
// Rotating first-set-bit search: scans mask from ptr upward with wrap to bit 0.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] mask_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             found_o,
    output logic [ID_W-1:0]  idx_o,
    output logic [N_REQ-1:0] onehot_o
);

    always_comb begin
        int j;
        j        = 0;
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!found_o && mask_i[j]) begin
                found_o     = 1'b1;
                idx_o       = ID_W'(j);
                onehot_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a hold-time limit; grants are registered and one-hot.
//
//   state | meaning
//   IDLE  | no owner, gnt all zero
//   OWNED | exactly one owner, gnt_id/hold_cnt track it
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter_if.master bus
);

    if (N_REQ < 2) begin : g_bad_n_req
        $error("rr_arbiter: N_REQ must be >= 2");
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("rr_arbiter: MAX_HOLD must be >= 2");
    end

    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             preempt_q, preempt_d;

    logic [ID_W-1:0]  owner_nxt;
    logic             owner_req;
    logic [N_REQ-1:0] pick_mask;
    logic [ID_W-1:0]  pick_ptr;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic [N_REQ-1:0] pick_onehot;

    assign owner_nxt = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_W'(1);
    assign owner_req = |(bus.req & gnt_q);
    // Removing the owner covers both cases: on release its req is already low,
    // on preemption it must not win again.
    assign pick_mask = bus.req & ~gnt_q;
    assign pick_ptr  = (state_q == OWNED) ? owner_nxt : ptr_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .mask_i   (pick_mask),
        .ptr_i    (pick_ptr),
        .found_o  (pick_found),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = OWNED;
                    gnt_d      = pick_onehot;
                    gnt_id_d   = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    ptr_d      = owner_nxt;
                    hold_cnt_d = '0;
                    if (pick_found) begin
                        gnt_d    = pick_onehot;
                        gnt_id_d = pick_idx;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end else if (hold_cnt_q == HOLD_LIM && pick_found) begin
                    ptr_d      = owner_nxt;
                    gnt_d      = pick_onehot;
                    gnt_id_d   = pick_idx;
                    hold_cnt_d = '0;
                    preempt_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_LIM) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = (state_q == OWNED);
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scenario bench for rr_arbiter (N_REQ=3, MAX_HOLD=4) with a behavioural reference model.
module tb_rr_arbiter;

    localparam int N        = 3;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rr_arbiter_if #(.N_REQ(N)) arb_if ();

    rr_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (arb_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 when idle), rotation start and cycles held.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_pre;

    function automatic int first_from(logic [N-1:0] mask, int from);
        for (int k = 0; k < N; k++) begin
            if (mask[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] v;
        v = '0;
        if (m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_pre   = 1'b0;
        end else begin
            logic [N-1:0] others;
            m_pre = 1'b0;
            if (m_owner < 0) begin
                m_owner = first_from(arb_if.req, m_ptr);
                m_hold  = 0;
            end else if (!arb_if.req[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = first_from(arb_if.req, m_ptr);
                m_hold  = 0;
            end else begin
                others = arb_if.req;
                others[m_owner] = 1'b0;
                if (m_hold >= MAX_HOLD - 1 && others != '0) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = first_from(others, m_ptr);
                    m_hold  = 0;
                    m_pre   = 1'b1;
                end else if (m_hold < MAX_HOLD - 1) begin
                    m_hold++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arb_if.req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arb_if.req = 3'b111;
        step();
        step();
        total++;
        if (arb_if.gnt !== 3'b000 || arb_if.busy !== 1'b0 || arb_if.preempt !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: gnt=%b busy=%b preempt=%b, want gnt=000 busy=0 preempt=0",
                     arb_if.gnt, arb_if.busy, arb_if.preempt);
        end
        rst = 1'b0;
        step();
        total++;
        if (arb_if.gnt !== 3'b001 || arb_if.gnt_id !== 2'd0 || arb_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: gnt=%b id=%0d busy=%b, want gnt=001 id=0 busy=1",
                     arb_if.gnt, arb_if.gnt_id, arb_if.busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        arb_if.req = 3'b100;
        step();
        total++;
        if (arb_if.gnt !== 3'b100 || arb_if.gnt_id !== 2'd2) begin
            bad++;
            $display("FAIL single_grant: gnt=%b id=%0d, want gnt=100 id=2", arb_if.gnt, arb_if.gnt_id);
        end
        for (int c = 0; c < 4; c++) step();
        arb_if.req = 3'b000;
        step();
        total++;
        if (arb_if.gnt !== 3'b000 || arb_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_release: gnt=%b busy=%b, want gnt=000 busy=0", arb_if.gnt, arb_if.busy);
        end
        arb_if.req = 3'b111;
        step();
        total++;
        if (arb_if.gnt !== 3'b001 || arb_if.gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL single_wrap: gnt=%b id=%0d, want gnt=001 id=0", arb_if.gnt, arb_if.gnt_id);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        logic         want_pre;
        do_reset();
        arb_if.req = 3'b111;
        step();
        for (int c = 0; c < 16; c++) begin
            want = '0;
            want[(c / MAX_HOLD) % N] = 1'b1;
            want_pre = (c > 0) && (c % MAX_HOLD == 0);
            total++;
            if (arb_if.gnt !== want || arb_if.preempt !== want_pre) begin
                bad++;
                $display("FAIL fairness c=%0d: gnt=%b preempt=%b, want gnt=%b preempt=%b",
                         c, arb_if.gnt, arb_if.preempt, want, want_pre);
            end
            step();
        end
    endtask

    task automatic test_handoff();
        do_reset();
        arb_if.req = 3'b011;
        step();
        total++;
        if (arb_if.gnt !== 3'b001) begin
            bad++;
            $display("FAIL handoff_first: gnt=%b, want 001", arb_if.gnt);
        end
        arb_if.req = 3'b010;
        step();
        total++;
        if (arb_if.gnt !== 3'b010 || arb_if.busy !== 1'b1 || arb_if.preempt !== 1'b0) begin
            bad++;
            $display("FAIL handoff_next: gnt=%b busy=%b preempt=%b, want gnt=010 busy=1 preempt=0",
                     arb_if.gnt, arb_if.busy, arb_if.preempt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        arb_if.req = 3'b010;
        step();
        for (int c = 0; c < 20; c++) begin
            total++;
            if (arb_if.gnt !== 3'b010 || arb_if.preempt !== 1'b0) begin
                bad++;
                $display("FAIL saturation_hold c=%0d: gnt=%b preempt=%b, want gnt=010 preempt=0",
                         c, arb_if.gnt, arb_if.preempt);
            end
            step();
        end
        arb_if.req = 3'b110;
        step();
        total++;
        if (arb_if.gnt !== 3'b100 || arb_if.preempt !== 1'b1) begin
            bad++;
            $display("FAIL saturation_preempt: gnt=%b preempt=%b, want gnt=100 preempt=1",
                     arb_if.gnt, arb_if.preempt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        arb_if.req = 3'b001;
        step();
        arb_if.req = 3'b010;
        step();
        total++;
        if (arb_if.gnt !== 3'b010) begin
            bad++;
            $display("FAIL async_setup: gnt=%b, want 010", arb_if.gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (arb_if.gnt !== 3'b000 || arb_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL async_mid: gnt=%b busy=%b, want gnt=000 busy=0", arb_if.gnt, arb_if.busy);
        end
        arb_if.req = 3'b111;
        step();
        rst = 1'b0;
        step();
        total++;
        if (arb_if.gnt !== 3'b001 || arb_if.gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL async_restart: gnt=%b id=%0d, want gnt=001 id=0", arb_if.gnt, arb_if.gnt_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] want;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 3) arb_if.req = N'($urandom_range(0, 7));
            step();
            want = exp_gnt();
            total++;
            if (arb_if.gnt !== want || arb_if.busy !== (m_owner >= 0) ||
                arb_if.preempt !== m_pre || !$onehot0(arb_if.gnt)) begin
                bad++;
                $display("FAIL random c=%0d: gnt=%b busy=%b preempt=%b, want gnt=%b busy=%b preempt=%b",
                         c, arb_if.gnt, arb_if.busy, arb_if.preempt, want, (m_owner >= 0), m_pre);
            end else if (m_owner >= 0 && arb_if.gnt_id !== 2'(m_owner)) begin
                bad++;
                $display("FAIL random_id c=%0d: gnt_id=%0d, want %0d", c, arb_if.gnt_id, m_owner);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        arb_if.req = '0;
        test_reset();
        test_single();
        test_fairness();
        test_handoff();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one combinational resource (e.g. the 3-input AND/OR reduction datapath) between N_REQ requesters.
- Issues a registered one-hot grant and holds it while the owner keeps its request high.
- Enforces a maximum hold time so that other waiting requesters are not starved.
- Sits between requester blocks and the shared datapath; the grant vector steers the datapath input mux.

Parameters:
- N_REQ, 3, number of requesters (must be >= 2).
- MAX_HOLD, 8, cycles an owner may hold the grant while others wait (must be >= 2).
- ID_W, $clog2(N_REQ), width of the grant index.
- CNT_W, $clog2(MAX_HOLD), width of the hold counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request, level; held high while the resource is needed.
- gnt  output  N_REQ  registered one-hot grant; all zero when idle.
- gnt_id  output  ID_W  index of the current owner; valid only when busy=1.
- busy  output  1  high while any grant is asserted.
- preempt  output  1  one-cycle pulse on the cycle a grant is taken away by the hold limit.

Behaviour:
- Clocking and reset: one clock. rst is asynchronous and active-high. While rst=1 the following hold immediately, independent of clk:
  - gnt=0, gnt_id=0, busy=0, preempt=0
  - rr pointer ptr=0, hold_cnt=0, state=IDLE
  - all req inputs are ignored.
- States: IDLE (no owner) and OWNED (exactly one owner). All outputs are registered.
- Winner selection (combinational):
  - Take the first set bit of a candidate mask, scanning from ptr upward with wrap N_REQ-1 -> 0.
  - Candidate mask = req, with the current owner removed when preempting.
- IDLE:
  - If req != 0, go to OWNED. The winner's gnt is set on the next edge (1-cycle latency) and hold_cnt is cleared.
  - If req == 0, stay in IDLE.
- OWNED, owner drops req (release):
  - Set ptr = owner+1 (mod N_REQ).
  - If another req is high, grant the next winner on the same edge (zero-bubble handoff).
  - Otherwise return to IDLE with gnt=0.
- OWNED, owner keeps req:
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - When hold_cnt == MAX_HOLD-1 and some other req is high, preempt: grant the next winner (excluding the owner), set ptr = old owner+1, clear hold_cnt, and pulse preempt=1 for exactly the cycle the new gnt first appears.
- Lone owner: if no other req is high, the owner keeps the grant indefinitely and preempt is never pulsed.
- Simultaneous release and hold limit: treat as a release, with no preempt pulse.
- New request arriving the same cycle as a release: it is eligible in that same selection.
- Invariants:
  - gnt is one-hot or zero at every cycle.
  - gnt_id equals the encoded gnt whenever busy=1.
  - busy equals |gnt.
- Out-of-range parameters: elaboration-time assertion failure.

Decomposition:
- Package rr_arb_pkg holds:
  - state enum arb_state_t {IDLE, OWNED}
  - default constants DEF_N_REQ=3 and DEF_MAX_HOLD=8.
- Sub-module rr_pick (combinational):
  - inputs: mask[N_REQ], ptr[ID_W]
  - outputs: found, idx[ID_W], onehot[N_REQ]
  - the top-level instantiates it once.

Test Plan:
All scenarios use N_REQ=3, MAX_HOLD=4.
1. Reset: hold rst=1 with req=3'b111 -> gnt=0, busy=0. Release rst -> gnt=3'b001, gnt_id=0 at the first edge after release.
2. Single requester: req=3'b100 at edge t -> gnt=3'b100, gnt_id=2 at t+1. Drop req at t+5 -> gnt=0, busy=0 at t+6. Then req=3'b111 -> gnt=3'b001 (ptr wrapped to 0).
3. Fairness: req=3'b111 held continuously -> gnt cycles 001, 010, 100, 001, 4 cycles each, with preempt=1 on the first cycle of every change.
4. Zero-bubble handoff: owner 0 with req=3'b011; drop req[0] -> gnt=3'b010 on the next edge, busy stays 1, preempt=0.
5. Saturation: only req[1] high for 20 cycles -> gnt=3'b010 throughout, preempt never asserted. Then raise req[2] -> gnt=3'b100 on the next edge with preempt=1.
6. Async reset mid-grant: assert rst between clock edges while gnt=3'b010 -> gnt=0 and busy=0 before the next clk edge. After release, arbitration restarts from ptr=0.
